// File: rtl/axis_rr_arbiter_if.sv
// AXI-stream bundle between N requesters and one shared sink.
// The arbiter takes the slave modport; the requester/sink side takes master.
interface axis_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS     = 4,
  parameter int SEL_WIDTH  = 2
);
  logic [INPUTS*DATA_WIDTH-1:0] idata;
  logic [INPUTS-1:0]            ilast;
  logic [INPUTS-1:0]            ivalid;
  logic [INPUTS-1:0]            iready;
  logic [DATA_WIDTH-1:0]        odata;
  logic                         olast;
  logic [SEL_WIDTH-1:0]         osel;
  logic                         ovalid;
  logic                         oready;

  modport slave (
    input  idata, ilast, ivalid, oready,
    output iready, odata, olast, osel, ovalid
  );

  modport master (
    output idata, ilast, ivalid, oready,
    input  iready, odata, olast, osel, ovalid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-stream arbiter with registered output and source tag.
// Grants last until end-of-packet or MAX_BURST beats, then re-arbitrate.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS     = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int MAX_BURST  = 16
) (
  input logic              clock,
  input logic              resetn,
  axis_rr_arbiter_if.slave axis
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_ptr;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_olast;
  logic [SEL_WIDTH-1:0]  r_osel;
  logic                  r_ovalid;

  logic [SEL_WIDTH-1:0]  w_pick;
  logic [SEL_WIDTH-1:0]  w_idx;
  logic                  w_req;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_sdata;
  logic                  w_slast;
  logic                  w_svalid;
  logic [INPUTS-1:0]     w_iready;
  logic                  w_room;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_grant;

  // Search ptr+1, ptr+2, ... ptr so the last grantee ranks lowest.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    w_req  = 1'b0;
    for (int k = 1; k <= INPUTS; k++) begin
      w_idx = SEL_WIDTH'((int'(r_ptr) + k) % INPUTS);
      w_req = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
        if (w_idx == SEL_WIDTH'(i)) begin
          w_req = axis.ivalid[i];
        end
      end
      if (!w_any && w_req) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_sdata  = '0;
    w_slast  = 1'b0;
    w_svalid = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (r_sel == SEL_WIDTH'(i)) begin
        w_sdata  = axis.idata[i*DATA_WIDTH +: DATA_WIDTH];
        w_slast  = axis.ilast[i];
        w_svalid = axis.ivalid[i];
      end
    end
  end

  assign w_room   = !r_ovalid || axis.oready;
  assign w_grant  = (r_state == IDLE) && w_any;
  assign w_accept = (r_state == BUSY) && w_svalid && w_room;
  assign w_done   = w_accept &&
                    (w_slast || (r_cnt == CW'(MAX_BURST - 1)));

  always_comb begin
    w_iready = '0;
    if ((r_state == BUSY) && w_room) begin
      for (int i = 0; i < INPUTS; i++) begin
        if (r_sel == SEL_WIDTH'(i)) begin
          w_iready[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_any) w_state_nxt = BUSY;
      BUSY: if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= SEL_WIDTH'(INPUTS - 1);
      r_sel <= '0;
      r_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_sel <= w_pick;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_ptr <= r_sel;
      end
    end
  end

  // Output beat holds while the sink stalls; a reset drops it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_odata  <= '0;
      r_olast  <= 1'b0;
      r_osel   <= '0;
      r_ovalid <= 1'b0;
    end else if (w_accept) begin
      r_odata  <= w_sdata;
      r_olast  <= w_slast;
      r_osel   <= r_sel;
      r_ovalid <= 1'b1;
    end else if (axis.oready) begin
      r_ovalid <= 1'b0;
    end
  end

  assign axis.iready = w_iready;
  assign axis.odata  = r_odata;
  assign axis.olast  = r_olast;
  assign axis.osel   = r_osel;
  assign axis.ovalid = r_ovalid;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-input packet sources, scoreboard on output.
// Built with MAX_BURST=4 so burst splitting is reachable with short packets.
module tb_axis_rr_arbiter;
  localparam int DW = 8;
  localparam int NI = 4;
  localparam int SW = 2;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  axis_rr_arbiter_if #(
    .DATA_WIDTH(DW), .INPUTS(NI), .SEL_WIDTH(SW)
  ) bus ();

  axis_rr_arbiter #(
    .DATA_WIDTH(DW), .INPUTS(NI), .SEL_WIDTH(SW), .MAX_BURST(MB)
  ) dut (
    .clock (clk),
    .resetn(resetn),
    .axis  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW:0]    src_q [NI][$];
  logic [DW+SW:0] sb_q [$];
  logic [SW-1:0]  log_sel [$];
  logic [DW-1:0]  log_data [$];
  logic           log_last [$];
  int             log_cyc [$];
  logic [NI-1:0]  hs_r = '0;
  logic [DW:0]    drv_b;
  logic [DW+SW:0] sb_exp;

  // Sources: advance on the handshake seen at the previous rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (hs_r[i] && src_q[i].size() != 0) src_q[i].delete(0);
      if (src_q[i].size() != 0) begin
        drv_b = src_q[i][0];
        bus.ivalid[i] = 1'b1;
        bus.ilast[i] = drv_b[DW];
        bus.idata[i*DW +: DW] = drv_b[DW-1:0];
      end else begin
        bus.ivalid[i] = 1'b0;
        bus.ilast[i] = 1'b0;
        bus.idata[i*DW +: DW] = '0;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (bus.ovalid && bus.oready) begin
      log_sel.push_back(bus.osel);
      log_data.push_back(bus.odata);
      log_last.push_back(bus.olast);
      log_cyc.push_back(cyc);
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got sel=%0d data=%h, required no beat",
                 bus.osel, bus.odata);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({bus.osel, bus.olast, bus.odata} !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_beat: got %h, required %h",
                   {bus.osel, bus.olast, bus.odata}, sb_exp);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (bus.ivalid[i] && bus.iready[i] && src_q[i].size() != 0)
        sb_q.push_back({SW'(i), src_q[i][0]});
    end
    hs_r <= bus.ivalid & bus.iready;
  end

  task automatic clear_logs();
    log_sel.delete();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  task automatic wait_beats(input int n, output bit ok);
    for (int c = 0; c < 300 && log_sel.size() < n; c++) @(negedge clk);
    ok = log_sel.size() >= n;
  endtask

  task automatic test_reset();
    bit ok;
    bus.ivalid = '0;
    bus.ilast  = '0;
    bus.idata  = '0;
    bus.oready = 1'b1;
    #1 resetn = 1'b0;
    for (int i = 0; i < NI; i++)
      src_q[i].push_back({1'b1, DW'(32'h20 + i)});
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      #1 bus.oready = ~bus.oready;
      n_tests++;
      if (bus.ovalid !== 1'b0 || bus.iready !== '0 ||
          bus.odata !== '0 || bus.osel !== '0) begin
        n_fail++;
        $display("FAIL reset_out: got v=%b rdy=%b d=%h s=%0d, required 0",
                 bus.ovalid, bus.iready, bus.odata, bus.osel);
      end
    end
    bus.oready = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    wait_beats(4, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_timeout: got %0d beats, required 4",
               log_sel.size());
    end
    for (int k = 0; k < log_sel.size() && k < 4; k++) begin
      n_tests++;
      if (log_sel[k] !== SW'(k)) begin
        n_fail++;
        $display("FAIL reset_order[%0d]: got %0d, required %0d",
                 k, log_sel[k], k);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    clear_logs();
    @(posedge clk);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NI; i++)
        src_q[i].push_back({1'b1, DW'(32'h30 + r * 4 + i)});
    wait_beats(8, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d beats, required 8", log_sel.size());
    end
    for (int k = 0; k < log_sel.size() && k < 8; k++) begin
      n_tests++;
      if (log_sel[k] !== SW'(k % NI)) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d",
                 k, log_sel[k], k % NI);
      end
      if (k > 0) begin
        n_tests++;
        if (log_cyc[k] - log_cyc[k-1] != 2) begin
          n_fail++;
          $display("FAIL rr_gap[%0d]: got %0d cycles, required 2",
                   k, log_cyc[k] - log_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_single_input();
    bit ok;
    clear_logs();
    @(posedge clk);
    src_q[2].push_back({1'b0, 8'h10});
    src_q[2].push_back({1'b0, 8'h11});
    src_q[2].push_back({1'b1, 8'h12});
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.ivalid[2] !== 1'b1 || bus.iready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: got v=%b r=%b, required v=1 r=0",
               bus.ivalid[2], bus.iready[2]);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.iready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_rise: got %b, required 0100", bus.iready);
    end
    wait_beats(3, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout: got %0d, required 3", log_sel.size());
    end
    for (int k = 0; k < log_sel.size() && k < 3; k++) begin
      n_tests++;
      if (log_sel[k] !== 2'd2 || log_data[k] !== DW'(32'h10 + k) ||
          log_last[k] !== (k == 2) || log_cyc[k] - log_cyc[0] != k) begin
        n_fail++;
        $display("FAIL single_beat[%0d]: got s=%0d d=%h l=%b dc=%0d, required s=2 d=%h l=%b dc=%0d",
                 k, log_sel[k], log_data[k], log_last[k],
                 log_cyc[k] - log_cyc[0], DW'(32'h10 + k), k == 2, k);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    bus.oready = 1'b0;
    @(posedge clk);
    src_q[1].push_back({1'b0, 8'h40});
    src_q[1].push_back({1'b0, 8'h41});
    src_q[1].push_back({1'b1, 8'h42});
    for (int c = 0; c < 50 && !bus.ovalid; c++) @(negedge clk);
    n_tests++;
    if (bus.ovalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_timeout: got ovalid=%b, required 1", bus.ovalid);
    end
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      n_tests++;
      if (bus.odata !== 8'h40 || bus.olast !== 1'b0 || bus.osel !== 2'd1 ||
          bus.ovalid !== 1'b1 || bus.iready !== '0) begin
        n_fail++;
        $display("FAIL bp_hold: got d=%h l=%b s=%0d v=%b r=%b, required d=40 l=0 s=1 v=1 r=0",
                 bus.odata, bus.olast, bus.osel, bus.ovalid, bus.iready);
      end
    end
    bus.oready = 1'b1;
    wait_beats(3, ok);
    repeat (4) @(negedge clk);
    n_tests++;
    if (log_sel.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats, required 3", log_sel.size());
    end
    for (int k = 0; k < log_sel.size() && k < 3; k++) begin
      n_tests++;
      if (log_data[k] !== DW'(32'h40 + k)) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %h, required %h",
                 k, log_data[k], DW'(32'h40 + k));
      end
    end
  endtask

  task automatic test_burst_split();
    bit ok;
    logic [DW-1:0] exp_d [12];
    logic [SW-1:0] exp_s [12];
    exp_d = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61,
              8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
              2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    clear_logs();
    @(posedge clk);
    for (int b = 0; b < 10; b++)
      src_q[0].push_back({b == 9, DW'(32'h50 + b)});
    for (int c = 0; c < 50 && !bus.iready[0]; c++) @(negedge clk);
    n_tests++;
    if (bus.iready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL split_grant: got iready=%b, required bit0 set",
               bus.iready);
    end
    src_q[1].push_back({1'b0, 8'h60});
    src_q[1].push_back({1'b1, 8'h61});
    wait_beats(12, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL split_timeout: got %0d, required 12", log_sel.size());
    end
    for (int k = 0; k < log_sel.size() && k < 12; k++) begin
      n_tests++;
      if (log_sel[k] !== exp_s[k] || log_data[k] !== exp_d[k] ||
          log_last[k] !== (k == 5 || k == 11)) begin
        n_fail++;
        $display("FAIL split_beat[%0d]: got s=%0d d=%h l=%b, required s=%0d d=%h l=%b",
                 k, log_sel[k], log_data[k], log_last[k],
                 exp_s[k], exp_d[k], k == 5 || k == 11);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    clear_logs();
    @(posedge clk);
    for (int b = 0; b < 4; b++)
      src_q[3].push_back({b == 3, DW'(32'h70 + b)});
    wait_beats(1, ok);
    @(posedge clk);
    #2 resetn = 1'b0;
    for (int i = 0; i < NI; i++) src_q[i].delete();
    sb_q.delete();
    #1;
    n_tests++;
    if (bus.ovalid !== 1'b0 || bus.odata !== '0 || bus.olast !== 1'b0 ||
        bus.osel !== '0 || bus.iready !== '0) begin
      n_fail++;
      $display("FAIL midrst_out: got v=%b d=%h l=%b s=%0d r=%b, required 0",
               bus.ovalid, bus.odata, bus.olast, bus.osel, bus.iready);
    end
    @(negedge clk);
    resetn = 1'b1;
    clear_logs();
    @(posedge clk);
    for (int i = 0; i < NI; i++)
      src_q[i].push_back({1'b1, DW'(32'h80 + i)});
    wait_beats(4, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midrst_timeout: got %0d, required 4", log_sel.size());
    end
    for (int k = 0; k < log_sel.size() && k < 4; k++) begin
      n_tests++;
      if (log_sel[k] !== SW'(k)) begin
        n_fail++;
        $display("FAIL midrst_order[%0d]: got %0d, required %0d",
                 k, log_sel[k], k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_input();
    test_backpressure();
    test_burst_split();
    test_reset_mid_packet();
    repeat (4) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_left: got %0d beats pending, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
